// File: rtl/jt12_kon_pkg.sv
// jt12_kon_pkg
// Shared types and helpers for the key-on write path: the queued request
// entry, the FSM state encoding and the channel-code filter.
package jt12_kon_pkg;

  // Default slot-rotation length: 6 channels x 4 operators.
  localparam int KON_SLOTS = 24;

  // One queued key-on request: operator mask {S4,S3,S2,S1} and channel code.
  typedef struct packed {
    logic [3:0] op;
    logic [2:0] ch;
  } kon_req_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } kon_state_t;

  // Channel codes 3 and 7 do not address a channel.
  function automatic logic kon_ch_valid(input logic [2:0] ch);
    return (ch[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/jt12_kon_fifo.sv
// jt12_kon_fifo
// Synchronous FIFO of key-on requests. Pointers are one bit wider than the
// address so full and empty can be told apart; both flags are registered.
// A push while full or a pop while empty is ignored.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push, din  write request and entry
//   pop        remove head entry
//   dout       head entry (valid while empty is low)
//   full       DEPTH entries stored
//   empty      no entries stored
module jt12_kon_fifo
  import jt12_kon_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  kon_req_t din,
  input  logic     pop,
  output kon_req_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  kon_req_t      mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   wr_nxt;
  logic [AW:0]   rd_nxt;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  assign wr_nxt = wr_ptr + {{AW{1'b0}}, push_ok};
  assign rd_nxt = rd_ptr + {{AW{1'b0}}, pop_ok};

  assign dout = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      empty  <= (wr_nxt == rd_nxt);
      full   <= (wr_nxt[AW] != rd_nxt[AW]) &&
                (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/jt12_kon_wr.sv
// jt12_kon_wr
// Producer side of the key-on update interface. Valid writes to register
// 0x28 are queued and replayed one at a time; each request is held for
// exactly SLOTS cycles so every operator slot of the target channel sees it.
//
// State table:
//   state    | meaning
//   ST_IDLE  | no request presented; pops the queue head as soon as present
//   ST_SWEEP | request presented; cnt counts down the remaining slots
//
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   keyon_wr  one-cycle strobe, register 0x28 written
//   din       write data: [7:4] operator mask, [2:0] channel code
//   clr_ovf   clears ovf (a simultaneous drop wins)
//   up_keyon  request valid
//   keyon_ch  channel code of the current request
//   keyon_op  operator mask of the current request
//   full      queue full
//   busy      request active or queued
//   ovf       sticky: a valid write was lost to a full queue
module jt12_kon_wr
  import jt12_kon_pkg::*;
#(
  parameter int SLOTS = KON_SLOTS,
  parameter int DEPTH = 4
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       keyon_wr,
  input  logic [7:0] din,
  input  logic       clr_ovf,
  output logic       up_keyon,
  output logic [2:0] keyon_ch,
  output logic [3:0] keyon_op,
  output logic       full,
  output logic       busy,
  output logic       ovf
);

  localparam int CW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SLOTS - 1);

  kon_state_t    state;
  kon_state_t    state_nxt;
  logic [CW-1:0] cnt;
  kon_req_t      req_in;
  kon_req_t      head;
  logic          wr_ok;
  logic          drop;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          last_slot;
  logic          unused_din3;

  // din[3] carries no meaning for the key-on register.
  assign unused_din3 = din[3];

  assign req_in = '{op: din[7:4], ch: din[2:0]};
  assign wr_ok  = keyon_wr & kon_ch_valid(din[2:0]);
  // Full is sampled before any same-cycle pop frees a slot, so the write is
  // lost even if the queue drains this cycle.
  assign drop   = wr_ok & fifo_full;

  jt12_kon_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_ok),
    .din   (req_in),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign last_slot = (cnt == '0);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (last_slot) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = ST_SWEEP;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      keyon_ch <= '0;
      keyon_op <= '0;
      ovf      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        keyon_ch <= head.ch;
        keyon_op <= head.op;
        cnt      <= CNT_LOAD;
      end else if (state == ST_SWEEP && !last_slot) begin
        cnt <= cnt - 1'b1;
      end
      if (drop) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  assign up_keyon = (state == ST_SWEEP);
  assign full     = fifo_full;
  assign busy     = up_keyon | ~fifo_empty;

endmodule

// File: tb/tb_jt12_kon_wr.sv
module tb_jt12_kon_wr;

  localparam int SLOTS = 24;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       keyon_wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       clr_ovf = 1'b0;
  logic       up_keyon;
  logic [2:0] keyon_ch;
  logic [3:0] keyon_op;
  logic       full;
  logic       busy;
  logic       ovf;

  int errors = 0;
  int checks = 0;
  int run = 0;
  int last_run = 0;

  // Reference model: a list of pending requests plus the request being
  // presented and how many of its cycles remain.
  bit         m_act;
  int         m_rem;
  logic [2:0] m_ch;
  logic [3:0] m_op;
  logic       m_ovf;
  logic [6:0] m_q[$];

  jt12_kon_wr #(
    .SLOTS (SLOTS),
    .DEPTH (DEPTH)
  ) dut (
    .rst      (rst),
    .clk      (clk),
    .keyon_wr (keyon_wr),
    .din      (din),
    .clr_ovf  (clr_ovf),
    .up_keyon (up_keyon),
    .keyon_ch (keyon_ch),
    .keyon_op (keyon_op),
    .full     (full),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_act = 0;
    m_rem = 0;
    m_ch  = '0;
    m_op  = '0;
    m_ovf = 1'b0;
    m_q.delete();
  endfunction

  function automatic void model_edge(bit wr, logic [7:0] d, bit clr);
    int         size0;
    bit         valid;
    bit         lost;
    logic [6:0] e;
    size0 = m_q.size();
    valid = wr && (d[2:0] != 3'd3) && (d[2:0] != 3'd7);
    lost  = valid && (size0 >= DEPTH);
    if (m_act) begin
      m_rem--;
      if (m_rem == 0) m_act = 0;
    end
    if (!m_act && size0 > 0) begin
      e     = m_q.pop_front();
      m_op  = e[6:3];
      m_ch  = e[2:0];
      m_act = 1;
      m_rem = SLOTS;
    end
    if (valid && !lost) m_q.push_back({d[7:4], d[2:0]});
    if (lost) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("up_keyon", {7'd0, up_keyon}, {7'd0, m_act});
    chk("keyon_ch", {5'd0, keyon_ch}, {5'd0, m_ch});
    chk("keyon_op", {4'd0, keyon_op}, {4'd0, m_op});
    chk("full", {7'd0, full}, {7'd0, (m_q.size() == DEPTH)});
    chk("busy", {7'd0, busy}, {7'd0, (m_act || m_q.size() != 0)});
    chk("ovf", {7'd0, ovf}, {7'd0, m_ovf});
    if (up_keyon === 1'b1) run++;
    else begin
      if (run > 0) last_run = run;
      run = 0;
    end
  endtask

  task automatic step(input bit wr, input logic [7:0] d, input bit clr);
    keyon_wr = wr;
    din      = d;
    clr_ovf  = clr;
    @(posedge clk);
    model_edge(wr, d, clr);
    #1;
    keyon_wr = 1'b0;
    clr_ovf  = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0);
  endtask

  initial begin
    logic [2:0] chs[5];
    chs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    // Reset
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // 1: single write, accepted one cycle after reset release
    step(1, 8'hF1, 0);
    chk("t1_not_yet", {7'd0, up_keyon}, 8'd0);
    idle(30);
    chk("t1_run_len", last_run[7:0], 8'd24);

    // 2: invalid channels filtered
    step(1, 8'h13, 0);
    step(1, 8'h27, 0);
    step(1, 8'h34, 0);
    idle(30);
    chk("t2_run_len", last_run[7:0], 8'd24);
    chk("t2_ovf", {7'd0, ovf}, 8'd0);

    // 3: five consecutive writes all accepted, 120 continuous cycles
    for (int i = 0; i < 5; i++) step(1, {4'(i + 3), 1'b0, chs[i]}, 0);
    chk("t3_ovf", {7'd0, ovf}, 8'd0);
    idle(130);
    chk("t3_run_len", last_run[7:0], 8'd120);

    // 4: sixth write dropped; clear; set wins over clear
    for (int i = 0; i < 6; i++) step(1, {4'hA, 1'b0, chs[i % 5]}, 0);
    chk("t4_ovf_set", {7'd0, ovf}, 8'd1);
    step(0, 8'h00, 1);
    chk("t4_ovf_clr", {7'd0, ovf}, 8'd0);
    step(1, 8'h95, 1);
    chk("t4_set_wins", {7'd0, ovf}, 8'd1);
    idle(130);

    // 5: reset mid-sweep with two queued entries
    step(1, 8'hF0, 0);
    step(1, 8'hF1, 0);
    step(1, 8'hF2, 0);
    idle(8);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("t5_busy_rst", {7'd0, busy}, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(40);
    chk("t5_no_replay", {7'd0, busy}, 8'd0);

    // 6: same channel, masks F then 0, adjacent windows
    step(1, 8'hF2, 0);
    step(1, 8'h02, 0);
    idle(55);
    chk("t6_run_len", last_run[7:0], 8'd48);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 15) == 0));
    end
    idle(150);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jt12_kon_wr.md
# jt12_kon_wr

Producer side of the key-on update interface. Captures CPU writes to the key-on register (0x28), queues them, and presents each one to the slot-multiplexed key-on logic as `up_keyon`/`keyon_ch`/`keyon_op`. Each request is held for exactly one full slot rotation, so every operator of the target channel passes through while the request is valid. The block sits between the register-write decoder and the key-on slot stage.

## Interface
Parameters:
- `SLOTS`, 24: slot-rotation length, in cycles, for which each request is held.
- `DEPTH`, 4: queue depth; must be a power of two, at least 2.

Ports:
- `rst` in 1: asynchronous, active-high reset.
- `clk` in 1: single clock; the slot pipeline advances one slot per cycle.
- `keyon_wr` in 1: one-cycle strobe; register 0x28 is written this cycle.
- `din` in 8: write data. Bits [7:4] are the operator mask {S4,S3,S2,S1}; bits [2:0] are the channel code.
- `clr_ovf` in 1: clears `ovf`.
- `up_keyon` out 1: a request is valid this cycle.
- `keyon_ch` out 3: channel code of the current request.
- `keyon_op` out 4: operator mask of the current request.
- `full` out 1: queue is full.
- `busy` out 1: a request is active or one is queued.
- `ovf` out 1: sticky flag; a valid write was lost.

## Operation
- **Input filter:** channel codes 3 and 7 are invalid. Such a write is discarded silently: it is not queued and does not set `ovf`.
- **Queue:** a valid write pushes the 7-bit entry {din[7:4], din[2:0]}.
  - If `full` is high in the write cycle, the entry is dropped and `ovf` is set. This holds even if a pop occurs in the same cycle.
- **States:**
  - IDLE:
    - `up_keyon`=0.
    - If the queue is non-empty: pop the head, latch it onto `keyon_ch`/`keyon_op`, set `up_keyon`=1, load `cnt`=SLOTS-1, go to SWEEP.
  - SWEEP:
    - `up_keyon`=1 and `cnt` decrements each cycle.
    - At `cnt`=0, if the queue is non-empty: pop the next entry, latch it, reload `cnt`=SLOTS-1, stay in SWEEP. `up_keyon` stays high with no gap.
    - At `cnt`=0, if the queue is empty: go to IDLE and drop `up_keyon`.
- **Output stability:** `keyon_ch`/`keyon_op` hold their last value while in IDLE. They change only on a pop.
- **Counter width:** `cnt` is clog2(SLOTS) bits and never wraps.
- **`busy`** = (state==SWEEP) | ~empty.
- **`ovf`** is set by a drop and cleared by `clr_ovf`. If both occur in the same cycle, set wins.

## Timing
- **Reset values:** `up_keyon`=0, `keyon_ch`=0, `keyon_op`=0, `full`=0, `busy`=0, `ovf`=0; queue empty, state IDLE, `cnt`=0.
  - Reset takes effect immediately, including mid-sweep. Any in-flight request is abandoned and not replayed.
- **Latency:** for `keyon_wr` sampled at edge E into an empty, idle block, `up_keyon` rises after edge E+1.
  - It stays high for exactly SLOTS cycles and falls after edge E+1+SLOTS.
- **Back-to-back requests:** request k+1's outputs take effect on the edge at which request k's SLOTS-th cycle ends.
- **Flags:** `full` and `empty` are registered, derived from read/write pointers one bit wider than clog2(DEPTH).
- **Simultaneous push and pop, queue not full:** both happen; occupancy is unchanged.
- **Write one cycle after reset release:** accepted normally.

## Structure
- **Package `jt12_kon_pkg`:**
  - localparam `KON_SLOTS`=24;
  - entry typedef `kon_req_t` {op[3:0], ch[2:0]};
  - function `kon_ch_valid(ch)` that rejects codes 3 and 7.
- **Sub-module `jt12_kon_fifo`:** DEPTH-entry synchronous FIFO for `kon_req_t`, with push/pop/full/empty.
- **Top level:** the state machine, counter and flag logic stay in `jt12_kon_wr`.

## Test plan
1. Reset, then a single write of `din`=0xF1 → entry {op=F, ch=1}:
   - `up_keyon` rises one edge after the write and is high for exactly 24 cycles;
   - `keyon_ch`=1 and `keyon_op`=F throughout;
   - `busy` falls with `up_keyon`.
2. Writes of `din`=0x13 and 0x27 (invalid channels), then 0x34 → only {op=3, ch=4} is issued; `ovf`=0.
3. Five valid writes on consecutive cycles with DEPTH=4 →
   - the first write is popped at the next edge, so all five are accepted;
   - the five requests are issued with `up_keyon` continuously high for 120 cycles;
   - channel order is preserved.
4. Six writes on consecutive cycles → the sixth is dropped, `ovf`=1; `clr_ovf` clears it; `clr_ovf` asserted together with a further drop leaves `ovf`=1.
5. Assert `rst` at cycle 10 of a sweep with 2 entries queued → all outputs are 0 immediately, and no request is issued after release.
6. Write the same channel twice with masks F then 0 → two adjacent 24-cycle windows, showing `keyon_op`=F then 0, with no idle cycle between them.
